// File: rtl/bpsk_modulator_pkg.sv
// Shared definitions for the BPSK transmitter: state encoding, table index width
// and the common sine table.
package bpsk_modulator_pkg;

    localparam int unsigned SCALE = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    // Parabolic sine: each half-period is x*(512-x), scaled so the peaks hit full scale.
    // Index 256 saturates to 2^31-1; index 768 is exactly -2^31.
    function automatic logic [31:0] scTable(input logic [SCALE-1:0] idx);
        logic [8:0]  x;
        logic [17:0] y;
        logic [32:0] mag;
        logic [32:0] neg;
        x   = idx[8:0];
        y   = 18'(x) * (18'd512 - 18'(x));
        mag = {y[17:0], 15'd0};
        neg = 33'd0 - mag;
        if (idx[9]) begin
            return neg[31:0];
        end else if (mag > 33'h0_7FFF_FFFF) begin
            return 32'h7FFF_FFFF;
        end else begin
            return mag[31:0];
        end
    endfunction

endpackage

// File: rtl/bpsk_phase_acc.sv
// Free-running carrier NCO: phase accumulator plus sine table lookup.
// Runs in every state, so carrier phase stays continuous across frames.
module bpsk_phase_acc
    import bpsk_modulator_pkg::*;
#(
    parameter int unsigned PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] freq_word,
    output logic [31:0]        c
);

    logic [PHASE_W-1:0] ph_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_q + freq_word;
        end
    end

    assign c = scTable(ph_q[PHASE_W-1 -: SCALE]);

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: byte stream in, preamble then MSB-first phase-keyed carrier out,
// SPS samples per symbol, one registered sample per cycle.
module bpsk_modulator
    import bpsk_modulator_pkg::*;
#(
    parameter int unsigned SPS           = 16,
    parameter int unsigned PREAMBLE_SYMS = 64,
    parameter int unsigned PHASE_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [31:0]        out,
    output logic               out_valid,
    output logic               busy,
    output logic               sym_strobe
);

    localparam int unsigned SW = $clog2(SPS);
    localparam int unsigned PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SPS - 1);
    localparam logic [PW-1:0] PRE_LAST    = PW'(PREAMBLE_SYMS - 1);

    state_t        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]   out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          sym_strobe_q, sym_strobe_d;

    logic [31:0] carrier;
    logic [31:0] neg_carrier;
    logic        cur_bit;
    logic        sym_last;

    bpsk_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk       (clk),
        .rst       (rst),
        .freq_word (freq_word),
        .c         (carrier)
    );

    // -(-2^31) does not fit, so it clamps to the most positive value.
    assign neg_carrier = (carrier == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - carrier);
    assign cur_bit     = (state_q == DATA) ? shreg_q[bit_idx_q] : 1'b0;
    assign sym_last    = (sample_cnt_q == SAMPLE_LAST);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        sample_cnt_d = sample_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        s_ready      = 1'b0;

        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    shreg_d      = s_data;
                    bit_idx_d    = 3'd7;
                    sample_cnt_d = '0;
                    pre_cnt_d    = '0;
                    state_d      = (PREAMBLE_SYMS == 0) ? DATA : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (sym_last) begin
                    sample_cnt_d = '0;
                    if (pre_cnt_q == PRE_LAST) begin
                        pre_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (sym_last) begin
                    sample_cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end else begin
                        // Last sample of the byte: a waiting byte follows with no gap.
                        s_ready = 1'b1;
                        if (s_valid) begin
                            shreg_d   = s_data;
                            bit_idx_d = 3'd7;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            s_ready = 1'b0;
        end
    end

    always_comb begin
        out_d        = 32'd0;
        out_valid_d  = 1'b0;
        sym_strobe_d = 1'b0;
        if (state_q != IDLE) begin
            out_d        = cur_bit ? neg_carrier : carrier;
            out_valid_d  = 1'b1;
            sym_strobe_d = (sample_cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            sample_cnt_q <= '0;
            pre_cnt_q    <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            sym_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            sample_cnt_q <= sample_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            sym_strobe_q <= sym_strobe_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign sym_strobe = sym_strobe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bpsk_modulator.sv
// Scoreboard bench for bpsk_modulator: a transaction model plans every frame sample,
// a monitor compares the DUT output stream against it.
module tb_bpsk_modulator;

    localparam int SPS = 4;
    localparam int PRE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] freq_word = 32'h1000_0000;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        busy;
    logic        sym_strobe;

    int total = 0;
    int bad = 0;
    bit rand_freq = 1'b0;

    typedef struct { bit b; bit strobe; } plan_t;
    typedef struct { logic [31:0] val; bit strobe; } exp_t;

    plan_t plan[$];
    exp_t  exp_q[$];
    logic [31:0] ph_model = 32'd0;

    bpsk_modulator #(
        .SPS           (SPS),
        .PREAMBLE_SYMS (PRE),
        .PHASE_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_word  (freq_word),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .sym_strobe (sym_strobe)
    );

    always #5 clk = ~clk;

    // Reference carrier: two parabolic half-waves, full scale at the quarter points.
    function automatic logic [31:0] ref_carrier(input logic [31:0] ph);
        longint idx = longint'(ph >> 22);
        longint x = idx % 512;
        longint y = x * (512 - x) * 32768;
        if (idx >= 512) return 32'(-y);
        if (y > 64'sd2147483647) return 32'h7FFF_FFFF;
        return 32'(y);
    endfunction

    function automatic logic [31:0] ref_mod(input logic [31:0] c, input bit b);
        longint v;
        if (!b) return c;
        v = -longint'($signed(c));
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: each cycle consumes one planned sample and accepts bytes.
    initial begin
        plan_t it;
        exp_t  e;
        bit    acc;
        bit    new_frame;
        forever begin
            @(posedge clk);
            if (rst) begin
                plan.delete();
                exp_q.delete();
                ph_model = 32'd0;
            end else begin
                acc       = s_valid && (plan.size() <= 1);
                new_frame = (plan.size() == 0);
                if (plan.size() > 0) begin
                    it       = plan.pop_front();
                    e.val    = ref_mod(ref_carrier(ph_model), it.b);
                    e.strobe = it.strobe;
                    exp_q.push_back(e);
                end
                if (acc) begin
                    if (new_frame) begin
                        for (int s = 0; s < PRE * SPS; s++) plan.push_back('{1'b0, (s % SPS) == 0});
                    end
                    for (int i = 7; i >= 0; i--) begin
                        for (int k = 0; k < SPS; k++) plan.push_back('{s_data[i], k == 0});
                    end
                end
                ph_model = ph_model + freq_word;
            end
        end
    end

    // Monitor: compares output stream and status against the model every cycle.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", out, e.val);
                    check("sym_strobe", {31'd0, sym_strobe}, {31'd0, e.strobe});
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("missing_sample", {31'd0, out_valid}, 32'd1);
                end
                check("idle_out", out, 32'd0);
                check("idle_strobe", {31'd0, sym_strobe}, 32'd0);
            end
            check("busy", {31'd0, busy}, {31'd0, plan.size() > 0});
            check("s_ready", {31'd0, s_ready}, {31'd0, !rst && plan.size() <= 1});
            check("phase", dut.u_phase_acc.ph_q, ph_model);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_freq && $urandom_range(0, 7) == 0) freq_word = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 400; i++) begin
            if (s_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset and idle carrier
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        // Single byte with preamble
        send_byte(8'hA5, 1'b0);
        wait_idle();
        repeat (3) tick();

        // Back-to-back bytes with s_valid held through the preamble
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b0);
        wait_idle();
        repeat (2) tick();

        // Saturation: park the phase at index 768 where the carrier is -2^31
        rst = 1'b1;
        tick();
        rst = 1'b0;
        freq_word = 32'hC000_0000;
        tick();
        freq_word = 32'd0;
        send_byte(8'hFF, 1'b0);
        repeat (10) tick();
        @(negedge clk);
        check("saturated_sample", out, 32'h7FFF_FFFF);
        wait_idle();

        // Reset in the middle of a data byte
        freq_word = 32'h0123_4567;
        send_byte(8'h3C, 1'b0);
        repeat (PRE * SPS + 4 * SPS + 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out", out, 32'd0);
        tick();
        send_byte(8'h96, 1'b0);
        wait_idle();

        // Random bytes, gaps, back-to-back runs and carrier retunes mid-frame
        rand_freq = 1'b1;
        for (int n = 0; n < 24; n++) begin
            bit keep = ($urandom_range(0, 2) == 0);
            send_byte(8'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 50)) tick();
        end
        s_valid = 1'b0;
        wait_idle();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
